// File: rtl/multicycle_controller.sv
// Multicycle Moore sequencer for the 16-bit MIPS datapath: FETCH/DECODE/EXEC/MEM/WB/BRANCH/HALT.
// Latency incl. FETCH: R-type/addi 4, lw 5+W, sw 4+W, beq/bne 3, undefined 2, halt word 2 then HALT.
// Backpressure: MEM holds while mem_ready is low; outputs never depend on mem_ready.
//
// Ports:
//   clock, resetn                   - clock and asynchronous active-low reset
//   Op, is_halt, Zero, mem_ready    - IR opcode, halt-word detect, ALU zero, memory handshake
//   IRWrite..MemWrite, ALUControl   - datapath strobes (forced low while resetn = 0)
//   state, halted                   - current state encoding, HALT indicator
//   cycle_count, instr_count        - wrapping performance counters, frozen in HALT
module multicycle_controller #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [3:0]       Op,
  input  logic             is_halt,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCSrc,
  output logic             RegDst,
  output logic             ALUSrc,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic [3:0]       ALUControl,
  output logic [2:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXEC    = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_BRANCH  = 3'd5,
    S_HALT    = 3'd6,
    S_ILLEGAL = 3'd7
  } state_t;

  state_t state_q, state_d;

  // Opcode classes
  logic is_rtype, is_addi, is_lw, is_sw, is_beq, is_bne, is_imm;
  logic [3:0] alu_op;

  assign is_rtype = (Op <= 4'd6);
  assign is_addi  = (Op == 4'd7);
  assign is_lw    = (Op == 4'd8);
  assign is_sw    = (Op == 4'd9);
  assign is_beq   = (Op == 4'd10);
  assign is_bne   = (Op == 4'd11);
  assign is_imm   = is_addi | is_lw | is_sw;

  always_comb begin
    alu_op = 4'b0000;
    case (Op)
      4'd0, 4'd7, 4'd8, 4'd9: alu_op = 4'b0010;
      4'd1, 4'd10, 4'd11:     alu_op = 4'b0110;
      4'd2:                   alu_op = 4'b0000;
      4'd3:                   alu_op = 4'b0001;
      4'd4:                   alu_op = 4'b1100;
      4'd5:                   alu_op = 4'b1101;
      4'd6:                   alu_op = 4'b0111;
      default:                alu_op = 4'b0000;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= S_FETCH;
    else         state_q <= state_d;
  end

  // Ungated strobe values; gated with resetn below
  logic       irwrite_c, pcwrite_c, pcsrc_c, regdst_c, alusrc_c;
  logic       memtoreg_c, regwrite_c, memread_c, memwrite_c;
  logic [3:0] aluctl_c;

  always_comb begin
    state_d    = S_FETCH;
    irwrite_c  = 1'b0;
    pcwrite_c  = 1'b0;
    pcsrc_c    = 1'b0;
    regdst_c   = 1'b0;
    alusrc_c   = 1'b0;
    memtoreg_c = 1'b0;
    regwrite_c = 1'b0;
    memread_c  = 1'b0;
    memwrite_c = 1'b0;
    aluctl_c   = 4'b0000;
    case (state_q)
      S_FETCH: begin
        irwrite_c = 1'b1;
        pcwrite_c = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        if (is_halt)                  state_d = S_HALT;
        else if (is_rtype || is_imm)  state_d = S_EXEC;
        else if (is_beq || is_bne)    state_d = S_BRANCH;
        else                          state_d = S_FETCH;
      end
      S_EXEC: begin
        aluctl_c = alu_op;
        alusrc_c = is_imm;
        state_d  = (is_lw || is_sw) ? S_MEM : S_WB;
      end
      S_MEM: begin
        // Address stays on the ALU for the whole access
        alusrc_c   = 1'b1;
        aluctl_c   = 4'b0010;
        memread_c  = is_lw;
        memwrite_c = is_sw;
        if (!mem_ready) state_d = S_MEM;
        else            state_d = is_lw ? S_WB : S_FETCH;
      end
      S_WB: begin
        regwrite_c = 1'b1;
        regdst_c   = is_rtype;
        memtoreg_c = is_lw;
        aluctl_c   = alu_op;
        alusrc_c   = is_imm;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        aluctl_c  = 4'b0110;
        pcsrc_c   = 1'b1;
        pcwrite_c = (is_beq & Zero) | (is_bne & ~Zero);
        state_d   = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Gating with resetn drops any pending write the instant reset asserts,
  // before the async state reset lands in FETCH with IRWrite/PCWrite high.
  assign IRWrite    = resetn & irwrite_c;
  assign PCWrite    = resetn & pcwrite_c;
  assign PCSrc      = resetn & pcsrc_c;
  assign RegDst     = resetn & regdst_c;
  assign ALUSrc     = resetn & alusrc_c;
  assign MemtoReg   = resetn & memtoreg_c;
  assign RegWrite   = resetn & regwrite_c;
  assign MemRead    = resetn & memread_c;
  assign MemWrite   = resetn & memwrite_c;
  assign ALUControl = resetn ? aluctl_c : 4'b0000;
  assign state      = state_q;
  assign halted     = (state_q == S_HALT);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      if (state_q != S_HALT) cycle_count <= cycle_count + CNT_W'(1);
      // FETCH always advances to DECODE, so every FETCH retires one fetch
      if (state_q == S_FETCH) instr_count <= instr_count + CNT_W'(1);
    end
  end

endmodule
